sum_block_accumulator: RTL

- Downstream consumer of the 8-bit operand adder (ui_in + uio_in) on the tile's pin interface.
- Accepts adder results over a valid/ready handshake and accumulates BLOCK_LEN samples into a saturating accumulator.
- Emits each block total as two bytes, low byte first, so it fits the 8-bit output pins.
- Applies backpressure to the adder side while the result is being drained.

---
 rtl/sum_block_accumulator.sv | 114 +++++++++++
 1 files changed

// File: rtl/sum_block_accumulator.sv
// Accumulates BLOCK_LEN adder results into a saturating sum and drains each
// block total as two bytes (low byte first) over a valid/ready output.
//
// state   | meaning
// ACCUM   | taking samples, sum_ready follows ena
// EMIT_LO | presenting result[7:0], input stalled
// EMIT_HI | presenting result[15:8] with out_last and out_sat, input stalled
module sum_block_accumulator #(
  parameter int BLOCK_LEN = 16,
  parameter int ACC_WIDTH = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       clear,
  input  logic [7:0] sum_in,
  input  logic       sum_valid,
  output logic       sum_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       out_sat
);

  localparam int CNT_W = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

  typedef enum logic [1:0] {ACCUM, EMIT_LO, EMIT_HI} state_t;

  state_t                 state, state_nxt;
  logic [ACC_WIDTH-1:0]   acc;
  logic [CNT_W-1:0]       count;
  logic                   sat;
  logic [15:0]            result;

  logic [ACC_WIDTH:0]     acc_sum;
  logic                   over;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic                   accept;
  logic                   final_sample;

  // One guard bit catches overflow; once acc sits at max any nonzero sample clamps again.
  assign acc_sum      = {1'b0, acc} + (ACC_WIDTH + 1)'(sum_in);
  assign over         = acc_sum[ACC_WIDTH];
  assign acc_next     = over ? '1 : acc_sum[ACC_WIDTH-1:0];
  assign accept       = sum_valid & sum_ready & ~clear;
  assign final_sample = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && final_sample) state_nxt = EMIT_LO;
      EMIT_LO: if (out_ready)              state_nxt = EMIT_HI;
      EMIT_HI: if (out_ready)              state_nxt = ACCUM;
      default:                             state_nxt = ACCUM;
    endcase
    if (clear) state_nxt = ACCUM;
  end

  always_comb begin
    sum_ready = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    out_sat   = 1'b0;
    case (state)
      ACCUM: sum_ready = ena & rst_n;
      EMIT_LO: begin
        out_valid = 1'b1;
        out_data  = result[7:0];
      end
      EMIT_HI: begin
        out_valid = 1'b1;
        out_data  = result[15:8];
        out_last  = 1'b1;
        out_sat   = sat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      count  <= '0;
      sat    <= 1'b0;
      result <= 16'h0000;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else begin
      if (accept) begin
        sat <= sat | over;
        if (final_sample) begin
          result <= 16'(acc_next);
          acc    <= '0;
          count  <= '0;
        end else begin
          acc   <= acc_next;
          count <= count + 1'b1;
        end
      end
      if (state == EMIT_HI && out_ready) sat <= 1'b0;
    end
  end

endmodule
